fmul_arbiter: RTL
=================

# fmul_arbiter

Shares one combinational `fmul` instance (x1, x2 → y, ovf) among `NREQ` requesters using round-robin arbitration. Each requester has valid/ready handshakes on its operand and result channels. The block registers the operands and the result around the multiplier, so timing is closed at a fixed latency and the FPU core sees one multiply at a time. It sits between the core's FP issue ports and the shared multiplier.

## Interface
- `NREQ`, default 2: number of requesters, 2..8.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in NREQ: requester i offers an operand pair.
- `req_ready` out NREQ: one-hot or zero; requester i's operands are accepted this cycle.
- `req_x1` in NREQ×32: operand 1 per requester, IEEE single.
- `req_x2` in NREQ×32: operand 2 per requester.
- `resp_valid` out NREQ: one-hot or zero; the result for requester i is present.
- `resp_ready` in NREQ: requester i takes its result.
- `resp_y` out 32: product, shared bus, valid only with `resp_valid`.
- `resp_ovf` out 1: overflow flag from `fmul`, shared bus.
- `ovf_sticky` out NREQ: present only with FMUL_ARB_OVF_STICKY_EN.
- `ovf_clr` in NREQ: present only with FMUL_ARB_OVF_STICKY_EN.

## Operation
- FSM states:
  - IDLE → ISSUE on an accept (`req_valid[g] & req_ready[g]`).
  - ISSUE → EXEC unconditionally.
  - EXEC → RESP unconditionally.
  - RESP → IDLE on `resp_ready[g]`.
- `req_ready` may be nonzero only in IDLE. It is combinational from `req_valid`, the state and `last_grant`.
- Arbitration is round-robin. Priority starts at `last_grant+1` and wraps modulo NREQ. The winner is g. `last_grant` updates to g on accept.
- IDLE accept: the chosen x1, x2 and g are latched into `op1_q`, `op2_q`, `gnt_q`.
- ISSUE: the `fmul` inputs are driven from `op1_q`/`op2_q`. Its outputs are registered into `y_q`/`ovf_q` at the end of ISSUE.
- EXEC: reserved slack cycle. `y_q`/`ovf_q` are moved to the output registers.
- RESP: `resp_valid[gnt_q]`=1, and `resp_y`/`resp_ovf` hold stable until the handshake.
- `resp_valid` is never asserted to a requester other than `gnt_q`. `resp_ready` of non-granted requesters is ignored.
- Requesters may deassert `req_valid` without an accept; no state effect.
- All operands, including NaN, inf and denormal inputs, pass to `fmul` unchanged. The arbiter does no arithmetic.

## Timing
- Reset values: state IDLE, `last_grant`=NREQ-1 (so requester 0 wins first), `req_ready`=0, `resp_valid`=0, `resp_y`=0, `resp_ovf`=0, `ovf_sticky`=0.
- Accept in cycle T gives `resp_valid` high in cycle T+3 (ISSUE at T+1, EXEC at T+2).
- Result handshake in cycle R gives the next accept no earlier than R+1. Peak throughput is one op per 4 cycles.
- `resp_ready` held high gives the handshake in the first RESP cycle.
- Backpressure: RESP is held indefinitely. No other requester is accepted meanwhile.
- Simultaneous `req_valid` from all requesters: grants rotate 0,1,…,NREQ-1,0.
- `rst` asserted in any state: returns to reset values on the next edge. An in-flight op is discarded with no response.
- `ovf_clr[i]` and a new overflow for i in the same cycle: set wins.

## Configuration
- `FMUL_ARB_OVF_STICKY_EN`:
  - Defined: per-requester sticky bit `ovf_sticky[i]`, set on a RESP handshake with `resp_ovf`=1 for i, cleared by `ovf_clr[i]`.
  - Undefined: `ovf_sticky`/`ovf_clr` ports and logic are removed. `resp_ovf` is still reported per response.

## Structure
- Package `fmul_arb_pkg`:
  - state enum `fmul_arb_state_t` {IDLE, ISSUE, EXEC, RESP}
  - `FP_W`=32
  - `NREQ_MAX`=8
  - function `rr_pick(valid, last)` returning the index.
- One sub-module: the existing `fmul` (x1, x2, y, ovf), instantiated once, unmodified.
- Arbitration is an in-module function, not a separate module.

## Test plan
- Single op: req0 x1=0x40000000, x2=0x40400000 → resp_valid[0] at T+3, resp_y=0x40C00000, resp_ovf=0.
- Overflow: x1=0x7F000000, x2=0x40000000 → resp_y=0x7F800000, resp_ovf=1. With the macro, ovf_sticky[g]=1 until ovf_clr[g].
- Fairness: NREQ=3, all req_valid held high from reset → accept order 0,1,2,0,1,2. No requester is starved.
- Backpressure: resp_ready=0 for 6 cycles in RESP → resp_y/resp_valid stable, req_ready=0 throughout. Handshake on cycle 7, then the next accept at +1.
- Reset mid-op: assert rst during EXEC → the next cycle has resp_valid=0, state IDLE, last_grant=NREQ-1, and requester 0 is accepted first afterwards.
- Sign/zero: x1=0x80000000, x2=0x3F800000 → resp_y=0x80000000, resp_ovf=0.

Source files
------------

// File: rtl/fmul_arb_pkg.sv
// rtl/fmul_arb_pkg.sv - shared types, widths and round-robin pick for fmul_arbiter
package fmul_arb_pkg;

    localparam int FP_W     = 32;
    localparam int NREQ_MAX = 8;
    localparam int GNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        EXEC,
        RESP
    } fmul_arb_state_t;

    // valid is zero-padded to NREQ_MAX, so wrapping modulo NREQ_MAX visits
    // the live requesters in the same order as wrapping modulo NREQ.
    function automatic logic [GNT_W-1:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                                 input logic [GNT_W-1:0]    last);
        logic [GNT_W-1:0] idx;
        logic             found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NREQ_MAX; k++) begin
            idx = last + GNT_W'(k);
            if (!found && valid[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/fmul.sv
// rtl/fmul.sv - combinational IEEE single multiply, round-to-nearest-even, denormals flushed to zero
module fmul (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);

    logic        sgn;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0] prod;
    logic [9:0]  e_sum, e_n, e_r;
    logic [22:0] frac, frac_out;
    logic        guard, sticky, rnd;
    logic [24:0] m_r;

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        sgn    = x1[31] ^ x2[31];
        a_zero = (x1[30:23] == 8'h00);
        b_zero = (x2[30:23] == 8'h00);
        a_inf  = (x1[30:23] == 8'hFF) && (x1[22:0] == 23'h0);
        b_inf  = (x2[30:23] == 8'hFF) && (x2[22:0] == 23'h0);
        a_nan  = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'h0);
        b_nan  = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'h0);

        prod  = 48'({1'b1, x1[22:0]}) * 48'({1'b1, x2[22:0]});
        // Biased exponent kept in 10 bits; bit 9 flags a negative (underflowed) value.
        e_sum = {2'b00, x1[30:23]} + {2'b00, x2[30:23]} - 10'd127;
        e_n   = e_sum + {9'd0, prod[47]};

        if (prod[47]) begin
            frac   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            frac   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end

        rnd      = guard & (sticky | frac[0]);
        m_r      = {2'b01, frac} + {24'd0, rnd};
        frac_out = m_r[24] ? m_r[23:1] : m_r[22:0];
        e_r      = e_n + {9'd0, m_r[24]};

        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            y = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            y = {sgn, 8'hFF, 23'h0};
        end else if (a_zero || b_zero) begin
            y = {sgn, 31'h0};
        end else if (!e_r[9] && (e_r >= 10'd255)) begin
            y   = {sgn, 8'hFF, 23'h0};
            ovf = 1'b1;
        end else if (e_r[9] || (e_r == 10'd0)) begin
            y = {sgn, 31'h0};
        end else begin
            y = {sgn, e_r[7:0], frac_out};
        end
    end

endmodule

// File: rtl/fmul_arbiter.sv
// rtl/fmul_arbiter.sv - round-robin sharing of one fmul; FMUL_ARB_OVF_STICKY_EN adds per-requester sticky overflow
module fmul_arbiter
    import fmul_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][FP_W-1:0]  req_x1,
    input  logic [NREQ-1:0][FP_W-1:0]  req_x2,
    output logic [NREQ-1:0]            resp_valid,
    input  logic [NREQ-1:0]            resp_ready,
    output logic [FP_W-1:0]            resp_y,
    output logic                       resp_ovf
`ifdef FMUL_ARB_OVF_STICKY_EN
    ,
    output logic [NREQ-1:0]            ovf_sticky,
    input  logic [NREQ-1:0]            ovf_clr
`endif
);

    fmul_arb_state_t state_q, state_d;
    logic [GNT_W-1:0] last_q, last_d, gnt_q, gnt_d, pick;
    logic [FP_W-1:0]  op1_q, op1_d, op2_q, op2_d;
    logic [FP_W-1:0]  y_q, y_d, ry_q, ry_d;
    logic             ovf_q, ovf_d, rovf_q, rovf_d;
    logic [FP_W-1:0]  mul_y;
    logic             mul_ovf;
    logic             accept, resp_hs;

    logic [NREQ_MAX-1:0]           valid_pad, rrdy_pad;
    logic [NREQ_MAX-1:0][FP_W-1:0] x1_pad, x2_pad;

    fmul u_fmul (
        .x1  (op1_q),
        .x2  (op2_q),
        .y   (mul_y),
        .ovf (mul_ovf)
    );

    // Pad per-requester inputs so a GNT_W-bit index is always in range.
    always_comb begin
        valid_pad = NREQ_MAX'(req_valid);
        rrdy_pad  = NREQ_MAX'(resp_ready);
        x1_pad    = '0;
        x2_pad    = '0;
        for (int i = 0; i < NREQ; i++) begin
            x1_pad[i] = req_x1[i];
            x2_pad[i] = req_x2[i];
        end
    end

    always_comb begin
        pick    = rr_pick(valid_pad, last_q);
        accept  = (state_q == IDLE) && (|req_valid);
        resp_hs = (state_q == RESP) && rrdy_pad[gnt_q];
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i]  = accept && (pick == GNT_W'(i));
            resp_valid[i] = (state_q == RESP) && (gnt_q == GNT_W'(i));
        end
    end

    assign resp_y   = ry_q;
    assign resp_ovf = rovf_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        ry_d    = ry_q;
        rovf_d  = rovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    last_d  = pick;
                    gnt_d   = pick;
                    op1_d   = x1_pad[pick];
                    op2_d   = x2_pad[pick];
                end
            end
            ISSUE: begin
                y_d     = mul_y;
                ovf_d   = mul_ovf;
                state_d = EXEC;
            end
            EXEC: begin
                ry_d    = y_q;
                rovf_d  = ovf_q;
                state_d = RESP;
            end
            RESP: begin
                if (resp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= GNT_W'(NREQ - 1);
            gnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            ry_q    <= '0;
            rovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            ry_q    <= ry_d;
            rovf_q  <= rovf_d;
        end
    end

`ifdef FMUL_ARB_OVF_STICKY_EN
    logic [NREQ-1:0] sticky_q, sticky_d;

    // Set is OR-ed in after the clear so a same-cycle overflow wins.
    always_comb begin
        sticky_d = sticky_q & ~ovf_clr;
        for (int i = 0; i < NREQ; i++) begin
            if (resp_hs && rovf_q && (gnt_q == GNT_W'(i))) begin
                sticky_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ovf_sticky = sticky_q;
`endif

endmodule
